cache_mem_nway: RTL and testbench

//  Parametrised N-way set-associative tag/data store for the ARM core's data-cache path; successor to the fixed 2-way store.

---
 rtl/cache_pkg.sv | 14 +
 rtl/plru_tree.sv | 39 +++
 rtl/cache_mem_nway.sv | 181 ++++++++++++++++++
 tb/tb_cache_mem_nway.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the N-way cache tag/data store.
package cache_pkg;

    // Flush sequencer states.
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    // Behaviour on a CPU write that hits a resident line.
    localparam int WM_INVALIDATE = 0;
    localparam int WM_UPDATE     = 1;

endpackage : cache_pkg

// File: rtl/plru_tree.sv
// Tree pseudo-LRU helper for one set: picks the victim way and computes the
// tree bits after touching a way. Node 0 is the root, node n has children
// 2n+1 (lower half) and 2n+2 (upper half); a 0 bit points to the lower half.
module plru_tree #(
    parameter  int WAYS  = 4,
    localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-2:0]  tree_in,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim,
    output logic [WAYS-2:0]  tree_out
);

    localparam int LEVELS = WAY_W;

    // Walk from the root following the stored bits; the path is the victim index, MSB first.
    always_comb begin
        // NOTE: every output gets a default before any conditional update, so no latch is inferred.
        victim = '0;
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < (1 << l); k++) begin
                if (int'(victim >> (LEVELS - l)) == k)
                    victim[LEVELS-1-l] = tree_in[(1 << l) - 1 + k];
            end
        end
    end

    // Point every node on the touched way's path away from that way.
    always_comb begin
        tree_out = tree_in;
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < (1 << l); k++) begin
                if (int'(touch_way >> (LEVELS - l)) == k)
                    tree_out[(1 << l) - 1 + k] = ~touch_way[LEVELS-1-l];
            end
        end
    end

endmodule : plru_tree

// File: rtl/cache_mem_nway.sv
// N-way set-associative tag/data store with combinational lookup, fill and
// CPU-write handling, tree pseudo-LRU replacement and a sequenced flush.
module cache_mem_nway
    import cache_pkg::*;
#(
    parameter  int WAYS       = 4,
    parameter  int SETS       = 64,
    parameter  int TAG_W      = 10,
    parameter  int DATA_W     = 64,
    parameter  int WRITE_MODE = WM_INVALIDATE,
    localparam int INDEX_W    = $clog2(SETS),
    localparam int WAY_W      = (WAYS > 2) ? $clog2(WAYS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               R_EN,
    input  logic               W_EN,
    input  logic               lookup_en,
    input  logic               flush_req,
    input  logic [DATA_W-1:0]  data,
    input  logic [TAG_W-1:0]   tag,
    input  logic [INDEX_W-1:0] addr,
    output logic [DATA_W-1:0]  data_out,
    output logic               hit,
    output logic [WAY_W-1:0]   hit_way,
    output logic               busy
);

    // Storage: valid and PLRU bits are flops with reset; tag/data are plain RAM.
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-2:0]   plru_q   [SETS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS];

    flush_state_t       state_q, state_d;
    logic [INDEX_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [WAYS-1:0]  match_vec;
    logic             any_match;
    logic [WAY_W-1:0] match_way;
    logic             free_found;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] victim_way;
    logic [WAYS-2:0]  plru_next;

    logic             act_en;
    logic             wr_data_en;
    logic             wr_tag_en;
    logic             set_valid;
    logic             clr_valid;
    logic             touch_en;
    logic [WAY_W-1:0] wr_way;

    // Compare every way of the addressed set against the access tag.
    always_comb begin
        for (int w = 0; w < WAYS; w++)
            match_vec[w] = valid_q[addr][w] && (tag_mem[addr][w] == tag);
    end

    // Pick the lowest-index match and the lowest-index invalid way.
    always_comb begin
        any_match  = 1'b0;
        match_way  = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match_vec[w]) begin
                any_match = 1'b1;
                match_way = WAY_W'(w);
            end
            if (!valid_q[addr][w]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .tree_in   (plru_q[addr]),
        .touch_way (wr_way),
        .victim    (victim_way),
        .tree_out  (plru_next)
    );

    // Requests only act in IDLE and when no flush is being started; write beats fill beats lookup touch.
    assign act_en = (state_q == IDLE) && !flush_req;

    // Decode the single action taken on the addressed set this cycle.
    always_comb begin
        wr_data_en = 1'b0;
        wr_tag_en  = 1'b0;
        set_valid  = 1'b0;
        clr_valid  = 1'b0;
        touch_en   = 1'b0;
        wr_way     = match_way;
        if (act_en) begin
            if (W_EN) begin
                if (any_match) begin
                    if (WRITE_MODE == WM_UPDATE) begin
                        wr_data_en = 1'b1;
                        touch_en   = 1'b1;
                    end else begin
                        clr_valid  = 1'b1;
                    end
                end
            end else if (R_EN) begin
                wr_data_en = 1'b1;
                touch_en   = 1'b1;
                if (!any_match) begin
                    wr_way    = free_found ? free_way : victim_way;
                    wr_tag_en = 1'b1;
                    set_valid = 1'b1;
                end
            end else if (lookup_en && any_match) begin
                touch_en = 1'b1;
            end
        end
    end

    // Flush sequencer next state: one set per cycle, SETS cycles in total.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + INDEX_W'(1);
                if (flush_cnt_q == INDEX_W'(SETS - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Valid and PLRU bits: cleared by reset and by the flush walk, otherwise updated by the decoded action.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (state_q == FLUSH) begin
            valid_q[flush_cnt_q] <= '0;
            plru_q[flush_cnt_q]  <= '0;
        end else begin
            if (set_valid) valid_q[addr][wr_way] <= 1'b1;
            if (clr_valid) valid_q[addr][wr_way] <= 1'b0;
            if (touch_en)  plru_q[addr]          <= plru_next;
        end
    end

    // Tag and data arrays.
    always_ff @(posedge clk) begin
        // NOTE: tag/data have no reset so they map onto RAM; the valid bits alone decide whether contents count.
        if (wr_tag_en)  tag_mem[addr][wr_way]  <= tag;
        if (wr_data_en) data_mem[addr][wr_way] <= data;
    end

    assign busy     = (state_q == FLUSH);
    assign hit      = any_match && !busy;
    assign hit_way  = hit ? match_way : '0;
    assign data_out = hit ? data_mem[addr][match_way] : '0;

endmodule : cache_mem_nway

// File: tb/tb_cache_mem_nway.sv
// Bench for cache_mem_nway: three builds (4-way invalidate, 4-way update,
// 2-way invalidate) share one stimulus stream; a set-level model checks all
// outputs every negedge, and directed literals pin the expected behaviour.
module tb_cache_mem_nway;

    localparam int NM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_en = 1'b0, w_en = 1'b0, lookup_en = 1'b0, flush_req = 1'b0;
    logic [63:0] data = '0;
    logic [9:0]  tag = '0;
    logic [5:0]  addr = '0;

    logic [63:0] dout0, dout1, dout2;
    logic        hit0, hit1, hit2, busy0, busy1, busy2;
    logic [1:0]  way0, way1;
    logic [0:0]  way2;

    logic [63:0] o_data [NM];
    logic        o_hit  [NM];
    logic        o_busy [NM];
    logic [1:0]  o_way  [NM];

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    localparam logic [63:0] DA = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] DC = 64'hCCCC_0000_0000_000C;
    localparam logic [63:0] DD = 64'hDDDD_0000_0000_000D;
    localparam logic [63:0] DE = 64'hEEEE_0000_0000_000E;
    localparam logic [63:0] DF = 64'hFFFF_0000_0000_000F;
    localparam logic [63:0] D5 = 64'h5555_1234_5678_0005;

    always #5 clk = ~clk;

    cache_mem_nway #(.WAYS(4), .SETS(64), .TAG_W(10), .DATA_W(64), .WRITE_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .R_EN(r_en), .W_EN(w_en), .lookup_en(lookup_en),
        .flush_req(flush_req), .data(data), .tag(tag), .addr(addr),
        .data_out(dout0), .hit(hit0), .hit_way(way0), .busy(busy0));

    cache_mem_nway #(.WAYS(4), .SETS(64), .TAG_W(10), .DATA_W(64), .WRITE_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .R_EN(r_en), .W_EN(w_en), .lookup_en(lookup_en),
        .flush_req(flush_req), .data(data), .tag(tag), .addr(addr),
        .data_out(dout1), .hit(hit1), .hit_way(way1), .busy(busy1));

    cache_mem_nway #(.WAYS(2), .SETS(64), .TAG_W(10), .DATA_W(64), .WRITE_MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .R_EN(r_en), .W_EN(w_en), .lookup_en(lookup_en),
        .flush_req(flush_req), .data(data), .tag(tag), .addr(addr),
        .data_out(dout2), .hit(hit2), .hit_way(way2), .busy(busy2));

    always_comb begin
        o_data[0] = dout0; o_hit[0] = hit0; o_busy[0] = busy0; o_way[0] = way0;
        o_data[1] = dout1; o_hit[1] = hit1; o_busy[1] = busy1; o_way[1] = way1;
        o_data[2] = dout2; o_hit[2] = hit2; o_busy[2] = busy2; o_way[2] = {1'b0, way2};
    end

    // ---------------- reference model ----------------
    int          mways [NM] = '{4, 4, 2};
    int          mmode [NM] = '{0, 1, 0};
    bit          mv [NM][64][4];
    logic [9:0]  mt [NM][64][4];
    logic [63:0] md [NM][64][4];
    bit          mp [NM][64][3];
    bit          m_busy;
    int          m_cnt;

    function automatic int m_find(int m, int a, int t);
        for (int w = 0; w < mways[m]; w++)
            if (mv[m][a][w] && int'(mt[m][a][w]) == t) return w;
        return -1;
    endfunction

    // Victim: halve the way range, stepping into the half each node bit names.
    function automatic int m_victim(int m, int a);
        int lo, span, n;
        lo = 0; span = mways[m]; n = 0;
        while (span > 1) begin
            span = span / 2;
            if (mp[m][a][n]) begin lo = lo + span; n = 2 * n + 2; end
            else n = 2 * n + 1;
        end
        return lo;
    endfunction

    // Touch: every node on the way's path is made to name the other half.
    task automatic m_touch(int m, int a, int w);
        int lo, span, n;
        lo = 0; span = mways[m]; n = 0;
        while (span > 1) begin
            span = span / 2;
            if (w < lo + span) begin mp[m][a][n] = 1'b1; n = 2 * n + 1; end
            else begin mp[m][a][n] = 1'b0; lo = lo + span; n = 2 * n + 2; end
        end
    endtask

    task automatic m_clear_set(int a);
        for (int m = 0; m < NM; m++)
            for (int w = 0; w < 4; w++) begin
                mv[m][a][w] = 1'b0;
                if (w < 3) mp[m][a][w] = 1'b0;
            end
    endtask

    task automatic m_step(int m);
        int hw, a, t, fw;
        a = int'(addr); t = int'(tag);
        hw = m_find(m, a, t);
        if (w_en) begin
            if (hw >= 0) begin
                if (mmode[m] == 0) mv[m][a][hw] = 1'b0;
                else begin md[m][a][hw] = data; m_touch(m, a, hw); end
            end
        end else if (r_en) begin
            if (hw >= 0) begin
                md[m][a][hw] = data; m_touch(m, a, hw);
            end else begin
                fw = -1;
                for (int w = mways[m] - 1; w >= 0; w--) if (!mv[m][a][w]) fw = w;
                if (fw < 0) fw = m_victim(m, a);
                mt[m][a][fw] = tag; md[m][a][fw] = data; mv[m][a][fw] = 1'b1;
                m_touch(m, a, fw);
            end
        end else if (lookup_en && hw >= 0) begin
            m_touch(m, a, hw);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 64; a++) m_clear_set(a);
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_clear_set(m_cnt);
            if (m_cnt == 63) begin m_busy = 1'b0; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
        end else if (flush_req) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else begin
            for (int m = 0; m < NM; m++) m_step(m);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every build against the model on each negedge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int m = 0; m < NM; m++) begin
                int w;
                bit eh;
                w  = m_find(m, int'(addr), int'(tag));
                eh = !m_busy && (w >= 0);
                check($sformatf("model m%0d busy", m), 64'(o_busy[m]), 64'(m_busy));
                check($sformatf("model m%0d hit", m), 64'(o_hit[m]), 64'(eh));
                check($sformatf("model m%0d hit_way", m), 64'(o_way[m]), eh ? 64'(w) : 64'd0);
                check($sformatf("model m%0d data_out", m), o_data[m], eh ? md[m][int'(addr)][w] : 64'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(bit r, bit w, bit l, bit f, logic [5:0] a, logic [9:0] t, logic [63:0] d);
        r_en = r; w_en = w; lookup_en = l; flush_req = f;
        addr = a; tag = t; data = d;
        @(posedge clk); #1;
        r_en = 1'b0; w_en = 1'b0; lookup_en = 1'b0; flush_req = 1'b0;
    endtask

    task automatic look(logic [5:0] a, logic [9:0] t);
        r_en = 1'b0; w_en = 1'b0; lookup_en = 1'b0; flush_req = 1'b0;
        addr = a; tag = t;
        @(negedge clk); #1;
    endtask

    task automatic expect_line(int m, string nm, logic [5:0] a, logic [9:0] t,
                               bit eh, int ew, logic [63:0] ed);
        look(a, t);
        check({nm, " hit"}, 64'(o_hit[m]), 64'(eh));
        check({nm, " hit_way"}, 64'(o_way[m]), 64'(ew));
        check({nm, " data_out"}, o_data[m], ed);
    endtask

    int n_busy;

    initial begin
        // 1. reset state
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        cmp_en = 1'b1;
        expect_line(0, "reset lookup", 6'd5, 10'd0, 0, 0, 64'd0);
        check("reset busy", 64'(o_busy[0]), 64'd0);

        // 2. fill set 3 with tags 1..4, then tag 5 evicts way 0
        drive(1, 0, 0, 0, 6'd3, 10'd1, DA);
        drive(1, 0, 0, 0, 6'd3, 10'd2, DB);
        drive(1, 0, 0, 0, 6'd3, 10'd3, DC);
        drive(1, 0, 0, 0, 6'd3, 10'd4, DD);
        expect_line(0, "fill4 tag3", 6'd3, 10'd3, 1, 2, DC);
        drive(1, 0, 0, 0, 6'd3, 10'd5, D5);
        expect_line(0, "evict tag1", 6'd3, 10'd1, 0, 0, 64'd0);
        expect_line(0, "evict tag5", 6'd3, 10'd5, 1, 0, D5);
        expect_line(0, "evict tag2", 6'd3, 10'd2, 1, 1, DB);
        expect_line(0, "evict tag4", 6'd3, 10'd4, 1, 3, DD);
        expect_line(2, "2way tag5", 6'd3, 10'd5, 1, 0, D5);
        expect_line(2, "2way tag4", 6'd3, 10'd4, 1, 1, DD);
        expect_line(2, "2way tag3", 6'd3, 10'd3, 0, 0, 64'd0);

        // 5. flush: busy exactly 64 cycles, hit held 0, requests ignored
        addr = 6'd3; tag = 10'd5; flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0; lookup_en = 1'b1;
        n_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (!o_busy[0]) break;
            n_busy++;
            if (i == 0) check("flush hit forced 0", 64'(o_hit[0]), 64'd0);
            r_en      = (i == 10);
            flush_req = (i == 30);
            addr      = (i == 10) ? 6'd7 : 6'd3;
            tag       = (i == 10) ? 10'd7 : 10'd5;
            data      = DF;
        end
        check("flush busy cycles", 64'(n_busy), 64'd64);
        expect_line(0, "post-flush ignored fill", 6'd7, 10'd7, 0, 0, 64'd0);
        expect_line(0, "post-flush set3", 6'd3, 10'd5, 0, 0, 64'd0);

        // 3. refill, lookup touch on tag 1, then tag 5 evicts way 2
        drive(1, 0, 0, 0, 6'd3, 10'd1, DA);
        drive(1, 0, 0, 0, 6'd3, 10'd2, DB);
        drive(1, 0, 0, 0, 6'd3, 10'd3, DC);
        drive(1, 0, 0, 0, 6'd3, 10'd4, DD);
        drive(0, 0, 1, 0, 6'd3, 10'd1, 64'd0);
        drive(1, 0, 0, 0, 6'd3, 10'd5, D5);
        expect_line(0, "plru tag3 gone", 6'd3, 10'd3, 0, 0, 64'd0);
        expect_line(0, "plru tag5", 6'd3, 10'd5, 1, 2, D5);
        expect_line(0, "plru tag1", 6'd3, 10'd1, 1, 0, DA);

        // 4. CPU write hit on tag 2, then write to absent tag 9
        drive(0, 1, 0, 0, 6'd3, 10'd2, DE);
        expect_line(0, "wm0 tag2 invalid", 6'd3, 10'd2, 0, 0, 64'd0);
        expect_line(1, "wm1 tag2 updated", 6'd3, 10'd2, 1, 1, DE);
        drive(0, 1, 0, 0, 6'd3, 10'd9, DF);
        expect_line(0, "absent write tag4", 6'd3, 10'd4, 1, 3, DD);
        expect_line(0, "absent write tag9", 6'd3, 10'd9, 0, 0, 64'd0);

        // 6. R_EN+W_EN on a hit: only the write acts
        drive(1, 1, 0, 0, 6'd3, 10'd4, DF);
        expect_line(0, "rw wm0 tag4", 6'd3, 10'd4, 0, 0, 64'd0);
        expect_line(1, "rw wm1 tag4", 6'd3, 10'd4, 1, 3, DF);
        // fill of a resident tag updates in place; one invalidate removes it
        drive(1, 0, 0, 0, 6'd3, 10'd1, 64'h1111);
        expect_line(0, "resident refill", 6'd3, 10'd1, 1, 0, 64'h1111);
        drive(0, 1, 0, 0, 6'd3, 10'd1, 64'd0);
        expect_line(0, "no second copy", 6'd3, 10'd1, 0, 0, 64'd0);

        // index/tag extremes
        drive(1, 0, 0, 0, 6'd63, 10'h3FF, '1);
        drive(1, 0, 0, 0, 6'd0, 10'd0, 64'd0);
        expect_line(0, "set63 tag3ff", 6'd63, 10'h3FF, 1, 0, '1);
        expect_line(0, "set0 tag0", 6'd0, 10'd0, 1, 0, 64'd0);

        // 5b. reset asserted mid-flush
        drive(0, 0, 0, 1, 6'd0, 10'd0, 64'd0);
        repeat (19) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midflush rst busy m0", 64'(o_busy[0]), 64'd0);
        check("midflush rst busy m2", 64'(o_busy[2]), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        expect_line(0, "rst cleared set63", 6'd63, 10'h3FF, 0, 0, 64'd0);
        check("after rst busy", 64'(o_busy[0]), 64'd0);
        repeat (3) @(negedge clk);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_cache_mem_nway
